regfile_port_arbiter: RTL and testbench
=======================================

# regfile_port_arbiter

Arbitrates the banked per-warp `register_block` (16 warps × 16 registers × 8 lanes × 64 bit, two read ports, one write port, one shared `warp_selector`) between one operand-fetch requester and NUM_WB writeback requesters. Because all three ports share a single warp selector, the block picks one warp per cycle, grants the reads and writes that target it, and prevents read starvation. It drives `register_block` directly and returns registered operand data to the issue stage.

## Interface
- NUM_WB, 4, number of writeback requesters (2..8)
- LANES, 8, lanes per warp
- DATA_W, 64, register width
- ADDR_W, 4, register address width
- WARP_W, 4, warp index width
- STARVE_LIMIT, 3, cycles a read may wait before it preempts writes (1..15)
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- rd_req_valid / rd_req_ready  in/out  1  operand-fetch handshake
- rd_req_warp  in  WARP_W  warp to read
- rd_req_addr0, rd_req_addr1  in  ADDR_W  source register per port
- rd_req_use0, rd_req_use1  in  1  port needed
- rd_req_mask  in  LANES  active lanes
- rd_rsp_valid  out  1  one-cycle response pulse
- rd_rsp_data0, rd_rsp_data1  out  LANES*DATA_W  lane i at [i*DATA_W +: DATA_W]
- wb_valid / wb_ready  in/out  NUM_WB  per-requester writeback handshake
- wb_warp  in  NUM_WB*WARP_W, wb_addr  in  NUM_WB*ADDR_W, wb_mask  in  NUM_WB*LANES, wb_data  in  NUM_WB*LANES*DATA_W  packed per requester
- rf_warp_sel  out  WARP_W, rf_read_en_0/1  out  LANES, rf_raddr_0/1  out  ADDR_W, rf_write_en  out  LANES, rf_waddr  out  ADDR_W, rf_wdata  out  LANES*DATA_W  to `register_block`
- rf_rdata_0, rf_rdata_1  in  LANES*DATA_W  from `register_block` (combinational read)

## Operation
- Write candidate: round-robin among asserted wb_valid starting at pointer rr_ptr; at most one write granted per cycle.
- Default priority: write wins the warp selector; rf_warp_sel = winning write's warp.
- Read granted when: no write candidate; or read warp equals winning write warp (both granted, same cycle); or rd_wait == STARVE_LIMIT (read wins, no write granted, rr_ptr unchanged).
- rd_wait: increments (saturating at STARVE_LIMIT) each cycle rd_req_valid && !rd_req_ready; clears on read grant.
- rr_ptr: on a write grant to requester i, becomes (i+1) mod NUM_WB.
- Read grant: rf_read_en_p = rd_req_mask if rd_req_use_p else 0; rf_raddr_p = rd_req_addrp.
- Write grant: rf_write_en = wb_mask[i], rf_waddr/rf_wdata from requester i.
- No grant: all rf enables 0, rf_warp_sel holds previous value.
- Response: lanes with rf_read_en_p bit 0 return 0; unused port returns all-zero data.
- Same-cycle read and write of same register: see Configuration.

## Timing
- rd_req_ready, wb_ready, and all rf_* outputs are combinational from current requests and state; a grant occurs in the cycle valid && ready.
- Write committed at the posedge ending the grant cycle.
- Read data captured at the posedge ending the grant cycle; rd_rsp_valid high for exactly the following cycle, data held until the next response. No response back-pressure.
- Back-to-back reads: one per cycle, full throughput.
- Reset (asserted any time, including mid-grant): rd_rsp_valid=0, rd_rsp_data*=0, rd_wait=0, rr_ptr=0, rf_warp_sel register=0; all ready and rf enables forced 0 while rst is high; in-flight response dropped.

## Configuration
- RF_BYPASS_EN defined: when read and write are granted the same cycle, same warp, rf_waddr equals a used read address, and the lane is in wb_mask, that lane of the response carries the write data.
- Undefined: the response returns the pre-write register contents (rf_rdata as sampled).

## Test plan
- Reset then idle: all outputs 0; rd_req_valid=1, warp 5, addr0=3, use0=1, mask=FF -> rd_req_ready=1 same cycle, rd_rsp_valid pulses next cycle with warp-5 r3 data on all 8 lanes, data1=0.
- wb_valid=4'b1111, all warp 2: grants go 0,1,2,3,0 on consecutive cycles; rf_warp_sel=2 throughout.
- Continuous writes to warp 1 and read to warp 7, STARVE_LIMIT=3: read waits 3 cycles, granted on the 4th with wb_ready=0 that cycle; rd_wait then clears.
- Read of warp 4 r9 with write to warp 4 r9 (data 64'hDEAD_BEEF on lane 0, mask 01) the same cycle: both granted; lane 0 response = DEAD_BEEF with RF_BYPASS_EN, old value without; other lanes old value.
- Read mask 8'h0F, use1=0: lanes 4-7 of data0 and all of data1 are zero.
- Assert rst in the cycle after a read grant: rd_rsp_valid stays 0, rr_ptr returns to 0, first post-reset write grant goes to requester 0.

Source files
------------

// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - one-warp-per-cycle arbiter between operand fetch and writeback for register_block
// Optional RF_BYPASS_EN: forward same-cycle write data into the read response.
module regfile_port_arbiter #(
   parameter int NUM_WB       = 4,
   parameter int LANES        = 8,
   parameter int DATA_W       = 64,
   parameter int ADDR_W       = 4,
   parameter int WARP_W       = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        rd_req_valid,
   output logic                        rd_req_ready,
   input  logic [WARP_W-1:0]           rd_req_warp,
   input  logic [ADDR_W-1:0]           rd_req_addr0,
   input  logic [ADDR_W-1:0]           rd_req_addr1,
   input  logic                        rd_req_use0,
   input  logic                        rd_req_use1,
   input  logic [LANES-1:0]            rd_req_mask,
   output logic                        rd_rsp_valid,
   output logic [LANES*DATA_W-1:0]     rd_rsp_data0,
   output logic [LANES*DATA_W-1:0]     rd_rsp_data1,
   input  logic [NUM_WB-1:0]           wb_valid,
   output logic [NUM_WB-1:0]           wb_ready,
   input  logic [NUM_WB*WARP_W-1:0]    wb_warp,
   input  logic [NUM_WB*ADDR_W-1:0]    wb_addr,
   input  logic [NUM_WB*LANES-1:0]     wb_mask,
   input  logic [NUM_WB*LANES*DATA_W-1:0] wb_data,
   output logic [WARP_W-1:0]           rf_warp_sel,
   output logic [LANES-1:0]            rf_read_en_0,
   output logic [LANES-1:0]            rf_read_en_1,
   output logic [ADDR_W-1:0]           rf_raddr_0,
   output logic [ADDR_W-1:0]           rf_raddr_1,
   output logic [LANES-1:0]            rf_write_en,
   output logic [ADDR_W-1:0]           rf_waddr,
   output logic [LANES*DATA_W-1:0]     rf_wdata,
   input  logic [LANES*DATA_W-1:0]     rf_rdata_0,
   input  logic [LANES*DATA_W-1:0]     rf_rdata_1
);

   localparam int PTR_W = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;
   localparam int LD    = LANES * DATA_W;

   logic [PTR_W-1:0]  rr_ptr;
   logic [3:0]        rd_wait;
   logic [WARP_W-1:0] warp_q;
   logic              wr_any;
   logic [PTR_W-1:0]  wr_idx;
   logic [WARP_W-1:0] wr_warp;
   logic              starve;
   logic              rd_grant;
   logic              wr_grant;
   logic [LD-1:0]     rsp0_next;
   logic [LD-1:0]     rsp1_next;

   // Scan from the highest offset down so the lowest offset from rr_ptr wins.
   always_comb begin : wr_pick
      int j;
      wr_any = 1'b0;
      wr_idx = '0;
      j      = 0;
      for (int k = NUM_WB - 1; k >= 0; k--) begin
         j = (int'(rr_ptr) + k) % NUM_WB;
         if (wb_valid[j]) begin
            wr_any = 1'b1;
            wr_idx = PTR_W'(j);
         end
      end
   end

   assign wr_warp  = wb_warp[int'(wr_idx)*WARP_W +: WARP_W];
   assign starve   = rd_req_valid && (rd_wait == 4'(STARVE_LIMIT));
   assign rd_grant = !rst && rd_req_valid && (!wr_any || (rd_req_warp == wr_warp) || starve);
   assign wr_grant = !rst && wr_any && !starve;

   assign rd_req_ready = rd_grant;
   assign wb_ready     = wr_grant ? (NUM_WB'(1) << wr_idx) : '0;
   assign rf_warp_sel  = wr_grant ? wr_warp : (rd_grant ? rd_req_warp : warp_q);
   assign rf_read_en_0 = (rd_grant && rd_req_use0) ? rd_req_mask : '0;
   assign rf_read_en_1 = (rd_grant && rd_req_use1) ? rd_req_mask : '0;
   assign rf_raddr_0   = rd_req_addr0;
   assign rf_raddr_1   = rd_req_addr1;
   assign rf_write_en  = wr_grant ? wb_mask[int'(wr_idx)*LANES +: LANES] : '0;
   assign rf_waddr     = wb_addr[int'(wr_idx)*ADDR_W +: ADDR_W];
   assign rf_wdata     = wb_data[int'(wr_idx)*LD +: LD];

   // Read enables already imply a grant; a concurrent write grant implies the same warp.
   always_comb begin
      rsp0_next = '0;
      rsp1_next = '0;
      for (int l = 0; l < LANES; l++) begin
         if (rf_read_en_0[l])
            rsp0_next[l*DATA_W +: DATA_W] = rf_rdata_0[l*DATA_W +: DATA_W];
         if (rf_read_en_1[l])
            rsp1_next[l*DATA_W +: DATA_W] = rf_rdata_1[l*DATA_W +: DATA_W];
`ifdef RF_BYPASS_EN
         if (rf_read_en_0[l] && rf_write_en[l] && (rf_waddr == rf_raddr_0))
            rsp0_next[l*DATA_W +: DATA_W] = rf_wdata[l*DATA_W +: DATA_W];
         if (rf_read_en_1[l] && rf_write_en[l] && (rf_waddr == rf_raddr_1))
            rsp1_next[l*DATA_W +: DATA_W] = rf_wdata[l*DATA_W +: DATA_W];
`else
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_rsp_valid <= 1'b0;
         rd_rsp_data0 <= '0;
         rd_rsp_data1 <= '0;
         rd_wait      <= '0;
         rr_ptr       <= '0;
         warp_q       <= '0;
      end else begin
         rd_rsp_valid <= rd_grant;
         warp_q       <= rf_warp_sel;
         if (rd_grant) begin
            rd_rsp_data0 <= rsp0_next;
            rd_rsp_data1 <= rsp1_next;
         end
         if (wr_grant)
            rr_ptr <= (wr_idx == PTR_W'(NUM_WB - 1)) ? '0 : wr_idx + 1'b1;
         if (rd_grant)
            rd_wait <= '0;
         else if (rd_req_valid && (rd_wait != 4'(STARVE_LIMIT)))
            rd_wait <= rd_wait + 4'd1;
      end
   end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb/tb_regfile_port_arbiter.sv - scoreboard bench for regfile_port_arbiter with a register_block model
module tb_regfile_port_arbiter;
   localparam int NUM_WB = 4, LANES = 8, DATA_W = 64, ADDR_W = 4, WARP_W = 4, STARVE_LIMIT = 3;
   localparam int LD = LANES * DATA_W;

   logic clk, rst;
   logic rd_req_valid, rd_req_ready, rd_req_use0, rd_req_use1, rd_rsp_valid;
   logic [WARP_W-1:0] rd_req_warp, rf_warp_sel;
   logic [ADDR_W-1:0] rd_req_addr0, rd_req_addr1, rf_raddr_0, rf_raddr_1, rf_waddr;
   logic [LANES-1:0] rd_req_mask, rf_read_en_0, rf_read_en_1, rf_write_en;
   logic [LD-1:0] rd_rsp_data0, rd_rsp_data1, rf_wdata, rf_rdata_0, rf_rdata_1;
   logic [NUM_WB-1:0] wb_valid, wb_ready;
   logic [NUM_WB*WARP_W-1:0] wb_warp;
   logic [NUM_WB*ADDR_W-1:0] wb_addr;
   logic [NUM_WB*LANES-1:0] wb_mask;
   logic [NUM_WB*LD-1:0] wb_data;

   logic [DATA_W-1:0] mem [16][16][LANES];
   logic [LD-1:0] exp_q0[$], exp_q1[$];
   logic [LD-1:0] e0, e1;
   int errors = 0, checks = 0;

   regfile_port_arbiter #(.NUM_WB(NUM_WB), .LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
                          .WARP_W(WARP_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk(clk), .rst(rst),
      .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_warp(rd_req_warp),
      .rd_req_addr0(rd_req_addr0), .rd_req_addr1(rd_req_addr1),
      .rd_req_use0(rd_req_use0), .rd_req_use1(rd_req_use1), .rd_req_mask(rd_req_mask),
      .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data0(rd_rsp_data0), .rd_rsp_data1(rd_rsp_data1),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_warp(wb_warp), .wb_addr(wb_addr),
      .wb_mask(wb_mask), .wb_data(wb_data),
      .rf_warp_sel(rf_warp_sel), .rf_read_en_0(rf_read_en_0), .rf_read_en_1(rf_read_en_1),
      .rf_raddr_0(rf_raddr_0), .rf_raddr_1(rf_raddr_1), .rf_write_en(rf_write_en),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_rdata_0(rf_rdata_0), .rf_rdata_1(rf_rdata_1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [LD-1:0] got, input logic [LD-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] pat(input int w, input int a, input int l);
      return {16'hBEEF, 8'(w), 8'(a), 8'(l), 24'h123456};
   endfunction

   function automatic logic [LD-1:0] exp_rsp(input int w, input int a, input logic use_p,
                                             input logic [LANES-1:0] mask);
      logic [LD-1:0] r;
      r = '0;
      for (int l = 0; l < LANES; l++)
         if (use_p && mask[l]) r[l*DATA_W +: DATA_W] = pat(w, a, l);
      return r;
   endfunction

   // register_block model: reloads its known pattern on reset, combinational reads
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int w = 0; w < 16; w++)
            for (int a = 0; a < 16; a++)
               for (int l = 0; l < LANES; l++) mem[w][a][l] <= pat(w, a, l);
      end else begin
         for (int l = 0; l < LANES; l++)
            if (rf_write_en[l]) mem[rf_warp_sel][rf_waddr][l] <= rf_wdata[l*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      rf_rdata_0 = '0;
      rf_rdata_1 = '0;
      for (int l = 0; l < LANES; l++) begin
         rf_rdata_0[l*DATA_W +: DATA_W] = mem[rf_warp_sel][rf_raddr_0][l];
         rf_rdata_1[l*DATA_W +: DATA_W] = mem[rf_warp_sel][rf_raddr_1][l];
      end
   end

   always @(negedge clk) begin
      if (!rst && rd_rsp_valid) begin
         if (exp_q0.size() == 0) begin
            check("rsp_unexpected", LD'(1), LD'(0));
         end else begin
            e0 = exp_q0.pop_front();
            e1 = exp_q1.pop_front();
            check("rsp_data0", rd_rsp_data0, e0);
            check("rsp_data1", rd_rsp_data1, e1);
         end
      end
   end

   task automatic idle();
      rd_req_valid = 0; rd_req_warp = '0; rd_req_addr0 = '0; rd_req_addr1 = '0;
      rd_req_use0 = 0; rd_req_use1 = 0; rd_req_mask = '0;
      wb_valid = '0; wb_warp = '0; wb_addr = '0; wb_mask = '0; wb_data = '0;
   endtask

   task automatic set_rd(input int w, input int a0, input int a1, input logic u0, input logic u1,
                         input logic [LANES-1:0] m);
      rd_req_valid = 1; rd_req_warp = WARP_W'(w); rd_req_addr0 = ADDR_W'(a0);
      rd_req_addr1 = ADDR_W'(a1); rd_req_use0 = u0; rd_req_use1 = u1; rd_req_mask = m;
   endtask

   task automatic set_wb(input int i, input int w, input int a, input logic [LANES-1:0] m,
                         input logic [DATA_W-1:0] d);
      wb_valid[i] = 1'b1;
      wb_warp[i*WARP_W +: WARP_W] = WARP_W'(w);
      wb_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
      wb_mask[i*LANES +: LANES] = m;
      for (int l = 0; l < LANES; l++) wb_data[i*LD + l*DATA_W +: DATA_W] = d + DATA_W'(l);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [LD-1:0] x;
      rst = 1'b1;
      idle();
      repeat (3) @(negedge clk);
      #1;
      check("rst_warp_sel", LD'(rf_warp_sel), LD'(0));
      check("rst_rsp_valid", LD'(rd_rsp_valid), LD'(0));
      check("rst_rsp_data0", rd_rsp_data0, '0);
      check("rst_rsp_data1", rd_rsp_data1, '0);
      set_rd(5, 3, 0, 1, 0, 8'hFF);
      wb_valid = 4'b1111;
      #1;
      check("rst_rd_ready", LD'(rd_req_ready), LD'(0));
      check("rst_wb_ready", LD'(wb_ready), LD'(0));
      check("rst_read_en", LD'(rf_read_en_0), LD'(0));
      check("rst_write_en", LD'(rf_write_en), LD'(0));
      idle();
      @(negedge clk);
      rst = 1'b0;

      // first read after reset
      @(negedge clk);
      set_rd(5, 3, 0, 1, 0, 8'hFF);
      #1;
      check("rd1_ready", LD'(rd_req_ready), LD'(1));
      check("rd1_warp_sel", LD'(rf_warp_sel), LD'(5));
      check("rd1_read_en0", LD'(rf_read_en_0), LD'(8'hFF));
      check("rd1_read_en1", LD'(rf_read_en_1), LD'(0));
      exp_q0.push_back(exp_rsp(5, 3, 1, 8'hFF));
      exp_q1.push_back('0);
      @(negedge clk);
      idle();
      @(negedge clk);
      #1;
      check("rsp_pulse", LD'(rd_rsp_valid), LD'(0));
      check("rsp_hold", rd_rsp_data0, exp_rsp(5, 3, 1, 8'hFF));

      // round robin among four writers to warp 2
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         for (int i = 0; i < NUM_WB; i++) set_wb(i, 2, c, LANES'(8'h11 << i), 64'h5000 + 64'(c));
         #1;
         check("rr_grant", LD'(wb_ready), LD'(4'b0001 << (c % 4)));
         check("rr_warp_sel", LD'(rf_warp_sel), LD'(2));
         check("rr_write_en", LD'(rf_write_en), LD'(8'h11 << (c % 4)));
      end
      @(negedge clk);
      idle();

      // starvation: requester 0 writes warp 1 continuously, read targets warp 7
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         idle();
         set_rd(7, 5, 0, 1, 0, 8'hFF);
         set_wb(0, 1, 2, 8'hFF, 64'h7700);
         #1;
         check("starve_rd_ready", LD'(rd_req_ready), LD'(c == 3));
         check("starve_wb_ready", LD'(wb_ready), LD'((c == 3) ? 4'b0000 : 4'b0001));
         if (c == 3) begin
            exp_q0.push_back(exp_rsp(7, 5, 1, 8'hFF));
            exp_q1.push_back('0);
         end
      end
      @(negedge clk);
      idle();

      // same-cycle read and write of warp 4 r9, then read again after commit
      @(negedge clk);
      set_rd(4, 9, 0, 1, 0, 8'hFF);
      set_wb(2, 4, 9, 8'h01, 64'hDEAD_BEEF);
      #1;
      check("byp_rd_ready", LD'(rd_req_ready), LD'(1));
      check("byp_wb_ready", LD'(wb_ready), LD'(4'b0100));
      check("byp_warp_sel", LD'(rf_warp_sel), LD'(4));
      x = exp_rsp(4, 9, 1, 8'hFF);
`ifdef RF_BYPASS_EN
      x[DATA_W-1:0] = 64'hDEAD_BEEF;
`else
`endif
      exp_q0.push_back(x);
      exp_q1.push_back('0);
      @(negedge clk);
      idle();
      set_rd(4, 9, 0, 1, 0, 8'hFF);
      #1;
      check("post_wr_ready", LD'(rd_req_ready), LD'(1));
      x = exp_rsp(4, 9, 1, 8'hFF);
      x[DATA_W-1:0] = 64'hDEAD_BEEF;
      exp_q0.push_back(x);
      exp_q1.push_back('0);

      // lane masking and unused ports, back to back
      @(negedge clk);
      set_rd(3, 6, 0, 1, 0, 8'h0F);
      #1;
      check("mask_ready", LD'(rd_req_ready), LD'(1));
      exp_q0.push_back(exp_rsp(3, 6, 1, 8'h0F));
      exp_q1.push_back('0);
      @(negedge clk);
      set_rd(9, 0, 11, 0, 1, 8'hAA);
      #1;
      check("port1_ready", LD'(rd_req_ready), LD'(1));
      check("port1_read_en0", LD'(rf_read_en_0), LD'(0));
      exp_q0.push_back('0);
      exp_q1.push_back(exp_rsp(9, 11, 1, 8'hAA));
      @(negedge clk);
      idle();

      // reset in the cycle following a read grant
      @(negedge clk);
      set_rd(0, 1, 0, 1, 0, 8'hFF);
      #1;
      check("pre_rst_ready", LD'(rd_req_ready), LD'(1));
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle();
      #1;
      check("midrst_rsp_valid", LD'(rd_rsp_valid), LD'(0));
      check("midrst_rsp_data0", rd_rsp_data0, '0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NUM_WB; i++) set_wb(i, 6, 1, 8'hFF, 64'h9900);
      #1;
      check("post_rst_grant", LD'(wb_ready), LD'(4'b0001));
      @(negedge clk);
      idle();
      repeat (3) @(negedge clk);
      #1;
      check("sb_drain", LD'(exp_q0.size()), LD'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
